// File: rtl/vanilla_return_fifo.sv
// vanilla_return_fifo: buffers network return packets for the core-side
// response stage. Credit-type returns are not buffered; each one becomes a
// registered single-cycle credit_return_o pulse.
//
// Build option: define VANILLA_RETURN_FIFO_BYPASS_EN to present a packet
// arriving at an empty FIFO on returned_* in the same cycle. When the
// consumer takes it in that cycle, it is never written.
module vanilla_return_fifo #(
  parameter int data_width_p     = 32,
  parameter int reg_id_width_p   = 5,
  parameter int pkt_type_width_p = 2,
  parameter int credit_type_p    = 0,
  parameter int els_p            = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          in_v_i,
  input  logic [data_width_p-1:0]       in_data_i,
  input  logic [reg_id_width_p-1:0]     in_reg_id_i,
  input  logic [pkt_type_width_p-1:0]   in_pkt_type_i,
  output logic                          in_ready_o,
  output logic                          returned_v_o,
  output logic [data_width_p-1:0]       returned_data_o,
  output logic [reg_id_width_p-1:0]     returned_reg_id_o,
  output logic [pkt_type_width_p-1:0]   returned_pkt_type_o,
  output logic                          returned_fifo_full_o,
  input  logic                          returned_yumi_i,
  output logic                          credit_return_o,
  output logic [$clog2(els_p+1)-1:0]    count_o
);

  localparam int addr_width_lp  = $clog2(els_p);
  localparam int ptr_width_lp   = addr_width_lp + 1;
  localparam int count_width_lp = $clog2(els_p + 1);
  localparam int entry_width_lp = data_width_p + reg_id_width_p + pkt_type_width_p;

  logic [entry_width_lp-1:0] mem [els_p];

  // The pointers carry one extra wrap bit, so full and empty can be told apart.
  logic [ptr_width_lp-1:0]   rd_ptr;
  logic [ptr_width_lp-1:0]   wr_ptr;
  logic [ptr_width_lp-1:0]   occupancy;
  logic                      empty;
  logic                      full;
  logic                      accept;
  logic                      is_credit;
  logic                      enq;
  logic                      deq;
  logic                      write_en;
  logic [entry_width_lp-1:0] in_entry;
  logic [entry_width_lp-1:0] head_entry;
  logic [entry_width_lp-1:0] out_entry;
  logic                      credit_r;

  assign empty     = (rd_ptr == wr_ptr);
  assign full      = (rd_ptr[addr_width_lp] != wr_ptr[addr_width_lp])
                   && (rd_ptr[addr_width_lp-1:0] == wr_ptr[addr_width_lp-1:0]);
  assign occupancy = wr_ptr - rd_ptr;

  // Ready depends only on the stored state and on reset. It has no path
  // from yumi or valid.
  assign in_ready_o = reset_n_i & ~full;
  assign accept     = in_v_i & in_ready_o;
  assign is_credit  = (in_pkt_type_i == pkt_type_width_p'(credit_type_p));
  assign enq        = accept & ~is_credit;
  assign deq        = returned_yumi_i & ~empty;

  assign in_entry   = {in_data_i, in_reg_id_i, in_pkt_type_i};
  assign head_entry = mem[rd_ptr[addr_width_lp-1:0]];

`ifdef VANILLA_RETURN_FIFO_BYPASS_EN
  logic bypass;
  // A packet arriving at an empty FIFO is shown at once. If the consumer
  // takes it in that same cycle, the write is skipped.
  assign bypass       = empty & enq;
  assign write_en     = enq & ~(bypass & returned_yumi_i);
  assign returned_v_o = ~empty | bypass;
  assign out_entry    = bypass ? in_entry : head_entry;
`else
  assign write_en     = enq;
  assign returned_v_o = ~empty;
  assign out_entry    = head_entry;
`endif

  assign {returned_data_o, returned_reg_id_o, returned_pkt_type_o} = out_entry;
  assign returned_fifo_full_o = (occupancy == ptr_width_lp'(els_p));
  assign count_o              = count_width_lp'(occupancy);
  assign credit_return_o      = credit_r;

  // Payload storage has no reset; empty pointers hide stale contents.
  always_ff @(posedge clk_i) begin
    if (write_en) begin
      mem[wr_ptr[addr_width_lp-1:0]] <= in_entry;
    end
  end

  // Advance the pointers. The wrap bit toggles when the low bits roll over.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + 1'b1;
      if (deq)      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Each accepted credit packet becomes a one-cycle pulse on the next cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_r <= 1'b0;
    end else begin
      credit_r <= accept & is_credit;
    end
  end

`ifndef SYNTHESIS
  // Flag consumer misuse: a dequeue with no valid head, or a packet left
  // blocked while the FIFO is full and the consumer is not draining it.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(returned_yumi_i && !returned_v_o))
        else $error("vanilla_return_fifo: yumi asserted with no valid head");
      assert (!(returned_fifo_full_o && in_v_i && !returned_yumi_i))
        else $error("vanilla_return_fifo: full and not draining while a packet waits");
    end
  end
`endif

endmodule

// File: tb/tb_vanilla_return_fifo.sv
// tb_vanilla_return_fifo: directed and random stimulus for vanilla_return_fifo,
// compared against a queue-based reference model of the return buffer.
module tb_vanilla_return_fifo;

  localparam int ELS = 4;
  localparam logic [1:0] CREDIT = 2'd0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  reg_id;
    logic [1:0]  pkt_type;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_v = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_reg_id = '0;
  logic [1:0]  in_pkt_type = '0;
  logic        yumi = 1'b0;
  logic        in_ready;
  logic        returned_v;
  logic [31:0] returned_data;
  logic [4:0]  returned_reg_id;
  logic [1:0]  returned_pkt_type;
  logic        returned_full;
  logic        credit_return;
  logic [2:0]  count;

  pkt_t model_q[$];
  logic exp_credit = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  vanilla_return_fifo dut (
    .clk_i                (clk),
    .reset_n_i            (reset_n),
    .in_v_i               (in_v),
    .in_data_i            (in_data),
    .in_reg_id_i          (in_reg_id),
    .in_pkt_type_i        (in_pkt_type),
    .in_ready_o           (in_ready),
    .returned_v_o         (returned_v),
    .returned_data_o      (returned_data),
    .returned_reg_id_o    (returned_reg_id),
    .returned_pkt_type_o  (returned_pkt_type),
    .returned_fifo_full_o (returned_full),
    .returned_yumi_i      (yumi),
    .credit_return_o      (credit_return),
    .count_o              (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the reference model.
  task automatic checkOutput();
    chk("in_ready", 32'(in_ready), 32'(model_q.size() < ELS));
    chk("returned_v", 32'(returned_v), 32'(model_q.size() > 0));
    chk("count", 32'(count), 32'(model_q.size()));
    chk("full", 32'(returned_full), 32'(model_q.size() == ELS));
    chk("credit", 32'(credit_return), 32'(exp_credit));
    if (model_q.size() > 0) begin
      chk("head_data", returned_data, model_q[0].data);
      chk("head_reg_id", 32'(returned_reg_id), 32'(model_q[0].reg_id));
      chk("head_type", 32'(returned_pkt_type), 32'(model_q[0].pkt_type));
    end
  endtask

  task automatic checkResetState();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_v", 32'(returned_v), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(returned_full), 32'd0);
    chk("rst_credit", 32'(credit_return), 32'd0);
  endtask

  // Drive one cycle of inputs, update the model with the pre-edge state,
  // then return the inputs to idle and check the outputs.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] r,
                               input logic [1:0] t, input logic y);
    bit accept;
    accept = v && (model_q.size() < ELS);
    in_v = v; in_data = d; in_reg_id = r; in_pkt_type = t; yumi = y;
    @(posedge clk); #1;
    exp_credit = accept && (t == CREDIT);
    if (y && model_q.size() > 0) void'(model_q.pop_front());
    if (accept && t != CREDIT) model_q.push_back('{data: d, reg_id: r, pkt_type: t});
    in_v = 1'b0; yumi = 1'b0;
    checkOutput();
  endtask

  initial begin
    // Reset, then idle
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput();

    // Fill to full, then drain in order
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hA0 + 32'(i), 5'(i + 1), 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 5'd0, 2'd1, 1'b1);

    // Streaming with simultaneous enqueue and dequeue across the wrap
    applyStimulus(1'b1, 32'd0, 5'd7, 2'd2, 1'b0);
    for (int i = 1; i < 10; i++) applyStimulus(1'b1, 32'(i), 5'd7, 2'd2, 1'b1);
    applyStimulus(1'b0, 32'h0, 5'd0, 2'd1, 1'b1);

    // Credit pulses: a single one, then three back to back, with one entry held
    applyStimulus(1'b1, 32'hBEEF, 5'd9, 2'd3, 1'b0);
    applyStimulus(1'b1, 32'h1, 5'd1, CREDIT, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'd0, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(i), 5'd2, CREDIT, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'd0, 2'd1, 1'b1);

    // Full FIFO offered a packet while the head is dequeued
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hC0 + 32'(i), 5'(i), 2'd1, 1'b0);
    applyStimulus(1'b1, 32'hDEAD, 5'd31, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 5'd0, 2'd1, 1'b1);

    // Reset mid-operation with three entries and a pending credit pulse
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hE0 + 32'(i), 5'(i), 2'd1, 1'b0);
    applyStimulus(1'b1, 32'h0, 5'd0, CREDIT, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checkResetState();
    model_q.delete();
    exp_credit = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput();
    applyStimulus(1'b1, 32'hF0, 5'd3, 2'd1, 1'b0);
    applyStimulus(1'b1, 32'hF1, 5'd4, 2'd1, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'd0, 2'd1, 1'b1);
    applyStimulus(1'b0, 32'h0, 5'd0, 2'd1, 1'b1);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic v, y;
      logic [31:0] d;
      logic [4:0]  r;
      logic [1:0]  t;
      y = ($urandom_range(0, 1) == 1) && (model_q.size() > 0);
      v = ($urandom_range(0, 1) == 1);
      if (model_q.size() == ELS && !y) v = 1'b0;
      d = $urandom;
      r = 5'($urandom_range(0, 31));
      t = 2'($urandom_range(0, 3));
      applyStimulus(v, d, r, t, y);
    end
    for (int i = 0; i < ELS && model_q.size() > 0; i++) applyStimulus(1'b0, 32'h0, 5'd0, 2'd1, 1'b1);

`ifdef VANILLA_RETURN_FIFO_BYPASS_EN
    // Same-cycle bypass on an empty FIFO, consumed immediately
    exp_credit = 1'b0;
    in_v = 1'b1; in_data = 32'h55; in_reg_id = 5'd3; in_pkt_type = 2'd1; yumi = 1'b1;
    #1;
    chk("bypass_v", 32'(returned_v), 32'd1);
    chk("bypass_data", returned_data, 32'h55);
    @(posedge clk); #1;
    in_v = 1'b0; yumi = 1'b0;
    checkOutput();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vanilla_return_fifo.md
Name: vanilla_return_fifo

Overview:
- Buffers return packets arriving from the tile's network endpoint and presents the head entry to the core-side transmit/response stage as returned_v/data/reg_id/pkt_type.
- Drives returned_fifo_full so that stage can force writeback when the buffer is full.
- Credit-type return packets are not buffered. They are converted into a registered one-cycle credit_return_o pulse for the outstanding-credit counter.

Parameters:
- data_width_p, 32, return payload width
- reg_id_width_p, 5, register id width
- pkt_type_width_p, 2, return packet type field width
- credit_type_p, 0, encoding of the credit return type
- els_p, 4, FIFO depth; power of two, at least 2

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- in_v_i  in  1  return packet valid from endpoint
- in_data_i  in  data_width_p  return data
- in_reg_id_i  in  reg_id_width_p  destination register id
- in_pkt_type_i  in  pkt_type_width_p  return packet type
- in_ready_o  out  1  packet accepted when in_v_i & in_ready_o
- returned_v_o  out  1  head entry valid
- returned_data_o  out  data_width_p  head data
- returned_reg_id_o  out  reg_id_width_p  head reg id
- returned_pkt_type_o  out  pkt_type_width_p  head type
- returned_fifo_full_o  out  1  occupancy == els_p
- returned_yumi_i  in  1  consumer dequeues head this cycle
- credit_return_o  out  1  one-cycle pulse per accepted credit packet
- count_o  out  clog2(els_p+1)  current occupancy

Behaviour:
- Interface (already decided): one clock, clk_i. Reset reset_n_i is asynchronous and active-low.
- While reset_n_i=0, asynchronously:
  - read/write pointers = 0
  - count_o = 0
  - returned_v_o = 0, returned_fifo_full_o = 0, credit_return_o = 0
  - in_ready_o = 0
- Storage is a circular buffer with rd_ptr/wr_ptr of clog2(els_p)+1 bits; the MSB is the wrap bit.
  - empty when the pointers are fully equal
  - full when the low bits are equal and the wrap bits differ
- in_ready_o = ~full. It has no combinational dependence on returned_yumi_i or in_v_i.
- Enqueue: in_v_i & in_ready_o & (in_pkt_type_i != credit_type_p). Writes at wr_ptr and increments wr_ptr on the clock edge.
- Credit path: in_v_i & in_ready_o & (in_pkt_type_i == credit_type_p).
  - Nothing is stored.
  - credit_return_o = 1 on the following cycle only.
  - Back-to-back credit packets give back-to-back pulses.
- Dequeue: returned_yumi_i & returned_v_o increments rd_ptr.
- Latency: without the optional feature, an enqueued entry appears on returned_v_o the cycle after acceptance.
- returned_v_o = ~empty. returned_* fields show the entry at rd_ptr and hold stable until dequeued.
- Simultaneous enqueue and dequeue:
  - count unchanged, both pointers advance
  - legal at any non-full occupancy
  - at full, no enqueue is possible because in_ready_o=0
- count_o = wr_ptr - rd_ptr, modulo 2^(clog2(els_p)+1).
- returned_fifo_full_o = (count_o == els_p). It is registered-state derived, so the consumer sees it in the same cycle the head is valid.
- Pointer wrap: the low bits wrap from els_p-1 to 0 and the wrap bit toggles. No entry loss or duplication at the wrap.
- Error conditions, checked in simulation only and flagged with $error:
  - returned_yumi_i while returned_v_o=0
  - returned_fifo_full_o=1 without returned_yumi_i
- Reset asserted mid-operation: all contents are discarded immediately. Any pending credit pulse is cancelled.

Optional Feature:
- Macro: VANILLA_RETURN_FIFO_BYPASS_EN.
- Defined: when the FIFO is empty and a non-credit packet is accepted, it is presented combinationally the same cycle:
  - returned_v_o=1, returned_* = in_* fields
  - if returned_yumi_i=1 that cycle, nothing is written and pointers are unchanged
  - otherwise the packet is written normally
  - credit packets are never bypassed
- Undefined: strict one-cycle enqueue-to-head latency; no combinational path from in_* to returned_*.

Test Plan:
- Reset then idle → in_ready_o=1, returned_v_o=0, count_o=0, credit_return_o=0.
- Enqueue data 0xA0..0xA3 with reg_id 1..4 and type 1, yumi held 0 (els_p=4) → count_o=4, returned_fifo_full_o=1, in_ready_o=0. Then yumi for 4 cycles → returns 0xA0..0xA3 in order, count_o=0.
- Continuous enqueue+yumi of 10 packets, data 0..9 → every value returned once in order across the pointer wrap; count_o stays 1.
- Credit packet (type=credit_type_p) accepted at cycle t → credit_return_o=1 at t+1 only, count_o unchanged. Three consecutive credits → three consecutive pulses.
- Full FIFO with yumi=1 and in_v_i=1 the same cycle → head dequeued, new packet not accepted, count_o=3 next cycle, in_ready_o=1.
- reset_n_i pulled low mid-cycle with count_o=3 → returned_v_o drops immediately. After release, count_o=0 and previously stored data never appears.
- With VANILLA_RETURN_FIFO_BYPASS_EN defined: empty FIFO, in_v_i=1, data 0x55, yumi=1 → returned_data_o=0x55 same cycle, count_o remains 0.
